process_scheduler: RTL and testbench

- Parametrised hardware process manager for the multiprogrammed single-cycle CPU.
- Holds per-process saved PCs and an active mask, and counts the quantum of the running user process.
- Requests a PC redirect to the kernel save routine or the process-end routine, and picks the next process round-robin when the kernel asks.
- Partition 0 (pc < PART_SIZE) is the kernel/BIOS. User process p occupies [p*PART_SIZE, (p+1)*PART_SIZE).

---
 rtl/process_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_process_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/process_scheduler.sv
// Hardware process manager for the multiprogrammed single-cycle CPU: tracks saved PCs,
// the active-process mask and the running slice, and drives kernel redirects and dispatch.
module process_scheduler #(
    parameter int NUM_PROC  = 10,
    parameter int PART_SIZE = 300,
    parameter int PC_W      = 32,
    parameter int QUANTUM   = 8,
    parameter int SAVE_ADDR = 180,
    parameter int END_ADDR  = 236
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PC_W-1:0] pc,
    input  logic            instr_retire,
    input  logic            halt_in,
    input  logic            is_io,
    input  logic            proc_end,
    input  logic            load_valid,
    input  logic [3:0]      load_count,
    input  logic            dispatch_req,
    output logic            dispatch_ack,
    output logic [3:0]      next_pid,
    output logic [PC_W-1:0] next_pc,
    output logic            all_done,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic [3:0]      cur_pid,
    output logic [15:0]     active_mask,
    output logic [7:0]      quantum_cnt
);

    localparam logic [PC_W-1:0] SAVE_PC   = PC_W'(SAVE_ADDR);
    localparam logic [PC_W-1:0] END_PC    = PC_W'(END_ADDR);
    localparam logic [PC_W-1:0] PART_PC   = PC_W'(PART_SIZE);
    localparam logic [3:0]      MAX_PID   = 4'(NUM_PROC);
    localparam logic [7:0]      LAST_TICK = 8'(QUANTUM - 1);

    logic [PC_W-1:0] r_table [16];
    logic [15:0]     r_mask;
    logic [3:0]      r_last_pid;
    logic [3:0]      r_cur_pid;
    logic [7:0]      r_qcnt;
    logic            r_redirect_valid;
    logic [PC_W-1:0] r_redirect_pc;
    logic            r_dispatch_ack;
    logic [3:0]      r_next_pid;
    logic [PC_W-1:0] r_next_pc;
    logic            r_all_done;

    logic [3:0]      w_load_n;
    logic [15:0]     w_load_mask;
    logic            w_running;
    logic [PC_W-1:0] w_base;
    logic [PC_W-1:0] w_offset;
    logic            w_in_part;
    logic            w_counted;
    logic            w_end;
    logic            w_expire;
    logic            w_load_ok;
    logic            w_disp_ok;
    logic [4:0]      w_cand;
    logic            w_found;
    logic [3:0]      w_sel_pid;

    assign w_load_n = (load_count > MAX_PID) ? MAX_PID : load_count;

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        w_load_mask = '0;
        for (int p = 1; p < 16; p++) begin
            w_load_mask[4'(p)] = (4'(p) <= w_load_n);
        end
    end

    // The partition test uses the offset so the upper bound never overflows PC_W.
    assign w_running = (r_cur_pid != 4'd0);
    assign w_base    = PC_W'(r_cur_pid) * PART_PC;
    assign w_offset  = pc - w_base;
    assign w_in_part = (pc >= w_base) && (w_offset < PART_PC);

    assign w_counted = w_running && instr_retire && !halt_in && w_in_part;
    assign w_end     = w_running && instr_retire && proc_end;
    assign w_expire  = w_counted && (r_qcnt == LAST_TICK);
    assign w_load_ok = load_valid && !w_running;
    assign w_disp_ok = dispatch_req && !w_running && !r_redirect_valid && !w_load_ok;

    // Round-robin search starting just after the last dispatched pid, wrapping at NUM_PROC.
    always_comb begin
        w_cand    = '0;
        w_found   = 1'b0;
        w_sel_pid = '0;
        for (int i = 1; i <= NUM_PROC; i++) begin
            w_cand = 5'(r_last_pid) + 5'(i);
            if (w_cand > 5'(NUM_PROC)) begin
                w_cand = w_cand - 5'(NUM_PROC);
            end
            if (!w_found && r_mask[w_cand[3:0]]) begin
                w_found   = 1'b1;
                w_sel_pid = w_cand[3:0];
            end
        end
    end

    // NOTE: state is updated with non-blocking '<=' so every register samples the
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: the PC table is small and the kernel relies on clean entries after
            // reset, so it is cleared here rather than left as uninitialised storage.
            for (int p = 0; p < 16; p++) begin
                r_table[p] <= '0;
            end
            r_mask           <= '0;
            r_last_pid       <= '0;
            r_cur_pid        <= '0;
            r_qcnt           <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_dispatch_ack   <= 1'b0;
            r_next_pid       <= '0;
            r_next_pc        <= '0;
            r_all_done       <= 1'b0;
        end else begin
            r_redirect_valid <= 1'b0;
            r_dispatch_ack   <= 1'b0;
            r_all_done       <= 1'b0;

            if (w_load_ok) begin
                r_mask <= w_load_mask;
                for (int p = 1; p < 16; p++) begin
                    if (w_load_mask[4'(p)]) begin
                        r_table[4'(p)] <= PC_W'(p) * PART_PC;
                    end
                end
                r_last_pid <= '0;
                r_cur_pid  <= '0;
                r_qcnt     <= '0;
            end else if (w_end) begin
                r_mask[r_cur_pid] <= 1'b0;
                r_cur_pid         <= '0;
                r_qcnt            <= '0;
                r_redirect_valid  <= 1'b1;
                r_redirect_pc     <= END_PC;
            end else if (w_expire) begin
                r_table[r_cur_pid] <= pc + PC_W'(1);
                r_cur_pid          <= '0;
                r_qcnt             <= '0;
                r_redirect_valid   <= 1'b1;
                r_redirect_pc      <= SAVE_PC;
            end else if (w_counted) begin
                r_qcnt <= is_io ? 8'd0 : r_qcnt + 8'd1;
            end

            // Accepted only with no process running, so it never overlaps the branches above.
            if (w_disp_ok) begin
                if (w_found) begin
                    r_dispatch_ack <= 1'b1;
                    r_next_pid     <= w_sel_pid;
                    r_next_pc      <= r_table[w_sel_pid];
                    r_cur_pid      <= w_sel_pid;
                    r_last_pid     <= w_sel_pid;
                    r_qcnt         <= '0;
                end else begin
                    r_all_done <= 1'b1;
                    r_next_pid <= '0;
                    r_next_pc  <= '0;
                end
            end
        end
    end

    assign dispatch_ack   = r_dispatch_ack;
    assign next_pid       = r_next_pid;
    assign next_pc        = r_next_pc;
    assign all_done       = r_all_done;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign cur_pid        = r_cur_pid;
    assign active_mask    = r_mask;
    assign quantum_cnt    = r_qcnt;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed and randomized bench for process_scheduler, compared every cycle
// against a behavioural model of the scheduling rules.
module tb_process_scheduler;

    localparam int NUM_PROC  = 10;
    localparam int PART_SIZE = 300;
    localparam int PC_W      = 32;
    localparam int QUANTUM   = 8;
    localparam int SAVE_ADDR = 180;
    localparam int END_ADDR  = 236;

    logic            clock = 1'b0;
    logic            reset;
    logic [PC_W-1:0] pc;
    logic            instr_retire;
    logic            halt_in;
    logic            is_io;
    logic            proc_end;
    logic            load_valid;
    logic [3:0]      load_count;
    logic            dispatch_req;
    logic            dispatch_ack;
    logic [3:0]      next_pid;
    logic [PC_W-1:0] next_pc;
    logic            all_done;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic [3:0]      cur_pid;
    logic [15:0]     active_mask;
    logic [7:0]      quantum_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          m_cur, m_last, m_q;
    bit          m_active [16];
    logic [31:0] m_saved  [16];
    bit          e_ack, e_done, e_rv;
    int          e_pid;
    logic [31:0] e_npc, e_rpc;

    process_scheduler #(
        .NUM_PROC (NUM_PROC),
        .PART_SIZE(PART_SIZE),
        .PC_W     (PC_W),
        .QUANTUM  (QUANTUM),
        .SAVE_ADDR(SAVE_ADDR),
        .END_ADDR (END_ADDR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc            (pc),
        .instr_retire  (instr_retire),
        .halt_in       (halt_in),
        .is_io         (is_io),
        .proc_end      (proc_end),
        .load_valid    (load_valid),
        .load_count    (load_count),
        .dispatch_req  (dispatch_req),
        .dispatch_ack  (dispatch_ack),
        .next_pid      (next_pid),
        .next_pc       (next_pc),
        .all_done      (all_done),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .cur_pid       (cur_pid),
        .active_mask   (active_mask),
        .quantum_cnt   (quantum_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = '0;
        for (int p = 1; p < 16; p++) m[p] = m_active[p];
        return m;
    endfunction

    // Apply the scheduling rules to the inputs now driven, clock once, then compare.
    task automatic tick();
        bit running, load_ok, prev_rv, found;
        int n;
        int order[$];
        prev_rv = e_rv;
        e_ack = 0; e_done = 0; e_rv = 0;
        if (!reset) begin
            m_cur = 0; m_last = 0; m_q = 0;
            for (int p = 0; p < 16; p++) begin
                m_active[p] = 0;
                m_saved[p]  = 0;
            end
            e_pid = 0; e_npc = 0; e_rpc = 0;
        end else begin
            running = (m_cur != 0);
            load_ok = load_valid && !running;
            if (load_ok) begin
                n = (int'(load_count) > NUM_PROC) ? NUM_PROC : int'(load_count);
                for (int p = 1; p < 16; p++) begin
                    m_active[p] = (p <= n);
                    if (p <= n) m_saved[p] = p * PART_SIZE;
                end
                m_last = 0; m_q = 0; m_cur = 0;
            end else if (running && instr_retire && proc_end) begin
                m_active[m_cur] = 0;
                m_cur = 0; m_q = 0;
                e_rv = 1; e_rpc = END_ADDR;
            end else if (running && instr_retire && !halt_in &&
                         (longint'(pc) / PART_SIZE == longint'(m_cur))) begin
                if (m_q == QUANTUM - 1) begin
                    m_saved[m_cur] = pc + 32'd1;
                    m_cur = 0; m_q = 0;
                    e_rv = 1; e_rpc = SAVE_ADDR;
                end else if (is_io) begin
                    m_q = 0;
                end else begin
                    m_q++;
                end
            end
            if (dispatch_req && !running && !prev_rv && !load_ok) begin
                for (int k = 1; k <= NUM_PROC; k++) order.push_back(((m_last + k - 1) % NUM_PROC) + 1);
                found = 0;
                foreach (order[k]) begin
                    if (!found && m_active[order[k]]) begin
                        found = 1;
                        e_pid = order[k];
                    end
                end
                if (found) begin
                    e_ack = 1; e_npc = m_saved[e_pid];
                    m_cur = e_pid; m_last = e_pid; m_q = 0;
                end else begin
                    e_done = 1; e_pid = 0; e_npc = 0;
                end
            end
        end

        @(posedge clock);
        #1;
        check("dispatch_ack", dispatch_ack, e_ack);
        check("next_pid", next_pid, e_pid);
        check("next_pc", next_pc, e_npc);
        check("all_done", all_done, e_done);
        check("redirect_valid", redirect_valid, e_rv);
        check("redirect_pc", redirect_pc, e_rpc);
        check("cur_pid", cur_pid, m_cur);
        check("active_mask", active_mask, model_mask());
        check("quantum_cnt", quantum_cnt, m_q);
        check("ack_redirect_excl", redirect_valid & dispatch_ack, 0);

        reset = 1; instr_retire = 0; halt_in = 0; is_io = 0; proc_end = 0;
        load_valid = 0; load_count = 0; dispatch_req = 0;
    endtask

    task automatic ret(input logic [31:0] p, input bit io, input bit pe, input bit hlt);
        pc = p; instr_retire = 1; is_io = io; proc_end = pe; halt_in = hlt;
        tick();
    endtask

    task automatic disp();
        dispatch_req = 1;
        tick();
    endtask

    task automatic slice(input logic [31:0] start);
        for (int i = 0; i < QUANTUM; i++) ret(start + 32'(i), 0, 0, 0);
    endtask

    initial begin
        m_cur = 0; m_last = 0; m_q = 0;
        e_ack = 0; e_done = 0; e_rv = 0; e_pid = 0; e_npc = 0; e_rpc = 0;
        for (int p = 0; p < 16; p++) begin
            m_active[p] = 0;
            m_saved[p]  = 0;
        end
        reset = 0; pc = 0; instr_retire = 0; halt_in = 0; is_io = 0; proc_end = 0;
        load_valid = 0; load_count = 0; dispatch_req = 0;

        // Reset and load three processes
        tick();
        check("rst_mask", active_mask, 16'h0000);
        tick();
        load_valid = 1; load_count = 3;
        tick();
        check("load3_mask", active_mask, 16'h000E);
        check("load3_cur", cur_pid, 0);

        // First dispatch and a full quantum
        disp();
        check("d1_ack", dispatch_ack, 1);
        check("d1_pid", next_pid, 1);
        check("d1_pc", next_pc, 300);
        slice(300);
        check("swap1_rv", redirect_valid, 1);
        check("swap1_rpc", redirect_pc, SAVE_ADDR);
        check("swap1_cur", cur_pid, 0);
        disp();
        check("disp_during_redirect", dispatch_ack, 0);

        // Round-robin order 2, 3, then 1 resumes at its saved PC
        disp();
        check("d2_pid", next_pid, 2);
        check("d2_pc", next_pc, 600);
        slice(600);
        tick();
        disp();
        check("d3_pid", next_pid, 3);
        check("d3_pc", next_pc, 900);
        slice(900);
        tick();
        disp();
        check("d4_pid", next_pid, 1);
        check("d4_pc", next_pc, 308);
        slice(308);
        tick();

        // pid 2 ends on the expiry retire: END wins over SAVE
        disp();
        check("d5_pid", next_pid, 2);
        for (int i = 0; i < QUANTUM - 1; i++) ret(608 + 32'(i), 0, 0, 0);
        ret(615, 0, 1, 0);
        check("end2_rpc", redirect_pc, END_ADDR);
        check("end2_mask", active_mask, 16'h000A);
        tick();
        disp();
        check("d6_pid", next_pid, 3);
        slice(908);
        tick();
        disp();
        check("d7_pid", next_pid, 1);
        check("d7_pc", next_pc, 316);

        // IO clears the count, halt freezes it, out-of-partition retires are ignored
        for (int i = 0; i < 5; i++) ret(316 + 32'(i), 0, 0, 0);
        check("q5", quantum_cnt, 5);
        ret(321, 1, 0, 0);
        check("io_q", quantum_cnt, 0);
        check("io_norv", redirect_valid, 0);
        check("io_cur", cur_pid, 1);
        ret(322, 0, 0, 0);
        ret(323, 0, 0, 0);
        for (int i = 0; i < 10; i++) ret(324, 0, 0, 1);
        check("halt_q", quantum_cnt, 2);
        ret(5000, 0, 0, 0);
        check("outpart_q", quantum_cnt, 2);

        // End everything, then all_done
        ret(324, 0, 1, 0);
        check("end1_mask", active_mask, 16'h0008);
        tick();
        disp();
        check("d8_pid", next_pid, 3);
        check("d8_pc", next_pc, 916);
        ret(916, 0, 1, 0);
        check("end3_mask", active_mask, 16'h0000);
        tick();
        disp();
        check("done_flag", all_done, 1);
        check("done_ack", dispatch_ack, 0);
        check("done_pid", next_pid, 0);
        tick();
        check("done_pulse", all_done, 0);

        // Load clamped to NUM_PROC; requests while running are ignored
        load_valid = 1; load_count = 12;
        tick();
        check("load12_mask", active_mask, 16'h07FE);
        disp();
        check("d9_pid", next_pid, 1);
        check("d9_pc", next_pc, 300);
        disp();
        check("busy_ack", dispatch_ack, 0);
        check("busy_cur", cur_pid, 1);
        load_valid = 1; load_count = 2;
        tick();
        check("busy_load_mask", active_mask, 16'h07FE);

        // Mid-operation reset, then reset with a concurrent load
        reset = 0; instr_retire = 1; pc = 301;
        tick();
        check("midrst_mask", active_mask, 0);
        check("midrst_cur", cur_pid, 0);
        reset = 0; load_valid = 1; load_count = 5;
        tick();
        check("rst_over_load", active_mask, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(99) != 0);
            load_valid   = ($urandom_range(19) == 0);
            load_count   = 4'($urandom_range(15));
            dispatch_req = ($urandom_range(3) == 0);
            instr_retire = ($urandom_range(3) != 0);
            halt_in      = ($urandom_range(7) == 0);
            is_io        = ($urandom_range(7) == 0);
            proc_end     = ($urandom_range(29) == 0);
            if (m_cur != 0 && $urandom_range(9) != 0)
                pc = 32'(m_cur * PART_SIZE) + 32'($urandom_range(PART_SIZE - 1));
            else
                pc = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
